// File: rtl/spi_responder.sv
// SPI responder (slave) oversampled on the system clock: synchronised CS/SCK/MOSI,
// one DATA_W-bit word in and out per frame slice, MSB first, with a one-word TX holding slot.
module spi_responder #(
  parameter int unsigned       DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = 'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_cs_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int unsigned       CTR_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CTR_W-1:0]  LAST_BIT = CTR_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_lead, sck_trail, sample_edge, shift_edge;

  state_t             state_q, state_n;
  logic [CTR_W-1:0]   bit_ctr_q, bit_ctr_n;
  logic               first_q, first_n;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_n;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_n;
  logic [DATA_W-1:0]  slot_q, slot_n;
  logic               slot_empty_q, slot_empty_n;
  logic [DATA_W-1:0]  rx_data_q, rx_data_n;
  logic               rx_valid_q, rx_valid_n;
  logic               underrun_q, underrun_n;
  logic               miso_q, miso_n;
  logic               oe_q, oe_n;
  logic               busy_q, busy_n;
  logic               load;

  // Pin synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync   <= '1;
      sck_sync  <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sck_d     <= CPOL;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign sck_lead    = (sck_d == CPOL) && (sck_s != CPOL);
  assign sck_trail   = (sck_d != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_ctr_q    <= '0;
      first_q      <= 1'b0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      slot_q       <= '0;
      slot_empty_q <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      bit_ctr_q    <= bit_ctr_n;
      first_q      <= first_n;
      tx_shift_q   <= tx_shift_n;
      rx_shift_q   <= rx_shift_n;
      slot_q       <= slot_n;
      slot_empty_q <= slot_empty_n;
      rx_data_q    <= rx_data_n;
      rx_valid_q   <= rx_valid_n;
      underrun_q   <= underrun_n;
      miso_q       <= miso_n;
      oe_q         <= oe_n;
      busy_q       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    bit_ctr_n    = bit_ctr_q;
    first_n      = first_q;
    tx_shift_n   = tx_shift_q;
    rx_shift_n   = rx_shift_q;
    slot_n       = slot_q;
    slot_empty_n = slot_empty_q;
    rx_data_n    = rx_data_q;
    rx_valid_n   = 1'b0;
    underrun_n   = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_n   = ACTIVE;
          bit_ctr_n = '0;
          first_n   = 1'b1;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        // A sample edge completes its word even when CS rises in the same cycle
        if (sample_edge) begin
          rx_shift_n = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_ctr_q == LAST_BIT) begin
            bit_ctr_n  = '0;
            rx_data_n  = rx_shift_n;
            rx_valid_n = 1'b1;
          end else begin
            bit_ctr_n = bit_ctr_q + CTR_W'(1);
          end
        end else if (shift_edge && !cs_rise) begin
          if (bit_ctr_q != '0)        tx_shift_n = tx_shift_q << 1;
          else if (CPHA && first_q)   first_n    = 1'b0;
          else                        load       = 1'b1;
        end
        if (cs_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Word load: slot first, then same-cycle bypass, else idle word
    if (load) begin
      if (!slot_empty_q) begin
        tx_shift_n   = slot_q;
        slot_empty_n = 1'b1;
      end else if (tx_valid_i) begin
        tx_shift_n = tx_data_i;
      end else begin
        tx_shift_n = IDLE_WORD;
        underrun_n = 1'b1;
      end
    end else if (slot_empty_q && tx_valid_i) begin
      slot_n       = tx_data_i;
      slot_empty_n = 1'b0;
    end

    busy_n = (state_n == ACTIVE);
    oe_n   = (state_n == ACTIVE);
    miso_n = (state_n == ACTIVE) ? tx_shift_n[DATA_W-1] : 1'b0;
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign tx_ready_o    = slot_empty_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a mode-0 and a mode-3 instance driven by a behavioural SPI master,
// scoreboarded against a queue model of the TX slot and the words the master sends.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs[2], sck[2], mosi[2], tx_valid[2];
  logic [7:0] tx_data[2];
  logic       miso[2], oe[2], ready[2], rxv[2], und[2], busy[2];
  logic [7:0] rxd[2];

  always #5 clk = ~clk;

  spi_responder u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .spi_cs_i(cs[0]), .spi_sck_i(sck[0]), .spi_mosi_i(mosi[0]),
    .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]),
    .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(ready[0]),
    .rx_data_o(rxd[0]), .rx_valid_o(rxv[0]), .tx_underrun_o(und[0]), .busy_o(busy[0])
  );

  spi_responder #(.CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .spi_cs_i(cs[1]), .spi_sck_i(sck[1]), .spi_mosi_i(mosi[1]),
    .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]),
    .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(ready[1]),
    .rx_data_o(rxd[1]), .rx_valid_o(rxv[1]), .tx_underrun_o(und[1]), .busy_o(busy[1])
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] mq0[$], mq1[$];     // model of words waiting for the responder to load
  logic [7:0] rxq0[$], rxq1[$];   // words the master has fully clocked in
  int         und_cnt[2], und_exp[2];
  logic [7:0] mo[4];
  bit         wr_en[4];
  logic [7:0] wr_data[4];
  logic       ready_after_fall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_size(input int s);
    return (s == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_push(input int s, input logic [7:0] w);
    if (s == 0) mq0.push_back(w); else mq1.push_back(w);
  endtask

  // Next word the responder shifts out: oldest pending write, else 0xFF with an underrun
  task automatic model_load(input int s, output logic [7:0] w);
    if (model_size(s) > 0) w = (s == 0) ? mq0.pop_front() : mq1.pop_front();
    else begin
      w = 8'hFF;
      und_exp[s]++;
    end
  endtask

  task automatic half_period();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input int s, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_valid[s] = 1'b1;
    tx_data[s]  = d;
    while (!ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_ready", 32'(ready[s]), 32'd1);
    if (ready[s]) begin
      @(posedge clk);
      model_push(s, d);
    end
    #1 tx_valid[s] = 1'b0;
  endtask

  task automatic check_reset_vals(input int s);
    check("rst_miso", 32'(miso[s]), 0);
    check("rst_oe", 32'(oe[s]), 0);
    check("rst_ready", 32'(ready[s]), 1);
    check("rst_rxdata", 32'(rxd[s]), 0);
    check("rst_rxvalid", 32'(rxv[s]), 0);
    check("rst_underrun", 32'(und[s]), 0);
    check("rst_busy", 32'(busy[s]), 0);
  endtask

  // One CS frame of nbytes; abort_bits>=0 stops after that many bits (CS rise or reset)
  task automatic run_frame(input int s, input int nbytes, input int abort_bits, input bit rst_mid);
    logic [7:0] expw[4];
    logic [7:0] got;
    int         bits_done = 0;
    bit         stop = 1'b0;
    @(negedge clk);
    cs[s] = 1'b0;
    model_load(s, expw[0]);
    half_period();
    ready_after_fall = ready[s];
    for (int i = 0; i < nbytes; i++) begin
      got = '0;
      for (int j = 0; j < 8; j++) begin
        if (abort_bits >= 0 && bits_done == abort_bits) begin
          stop = 1'b1;
          break;
        end
        if (s == 0) begin
          mosi[0] = mo[i][7-j];
          half_period();
          got = {got[6:0], miso[0]};
          sck[0] = 1'b1;
          if (j == 7) rxq0.push_back(mo[i]);
          if (j == 3 && wr_en[i]) do_write(0, wr_data[i]);
          half_period();
          if (!(i == nbytes - 1 && j == 7)) sck[0] = 1'b0;
        end else begin
          half_period();
          sck[1]  = 1'b0;
          mosi[1] = mo[i][7-j];
          if (j == 3 && wr_en[i]) do_write(1, wr_data[i]);
          half_period();
          got = {got[6:0], miso[1]};
          sck[1] = 1'b1;
          if (j == 7) rxq1.push_back(mo[i]);
        end
        bits_done++;
      end
      if (stop) break;
      check("miso_word", 32'(got), 32'(expw[i]));
      if (i < nbytes - 1) model_load(s, expw[i+1]);
    end
    if (stop && rst_mid) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals(0);
      check_reset_vals(1);
      cs[s] = 1'b1;
      mq0.delete();
      mq1.delete();
      half_period();
      rst = 1'b0;
      half_period();
    end else if (stop) begin
      cs[s] = 1'b1;
      half_period();
      sck[s] = (s == 1);
    end else if (s == 0) begin
      cs[0] = 1'b1;
      half_period();
      sck[0] = 1'b0;
    end else begin
      half_period();
      cs[1] = 1'b1;
    end
    repeat (10) @(negedge clk);
    check("post_busy", 32'(busy[s]), 0);
    check("post_oe", 32'(oe[s]), 0);
    check("post_miso", 32'(miso[s]), 0);
    check("rx_missing", 32'((s == 0) ? rxq0.size() : rxq1.size()), 0);
    check("underrun_count", 32'(und_cnt[s]), 32'(und_exp[s]));
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      mo[i] = '0;
      wr_en[i] = 1'b0;
      wr_data[i] = '0;
    end
  endtask

  // Pops the expected word whenever a responder reports a received word
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rxv[0]) begin
        if (rxq0.size() == 0) check("rx0_unexpected", 32'(rxv[0]), 0);
        else check("rx0_data", 32'(rxd[0]), 32'(rxq0.pop_front()));
      end
      if (rxv[1]) begin
        if (rxq1.size() == 0) check("rx1_unexpected", 32'(rxv[1]), 0);
        else check("rx1_data", 32'(rxd[1]), 32'(rxq1.pop_front()));
      end
      if (und[0]) und_cnt[0]++;
      if (und[1]) und_cnt[1]++;
    end
  endtask

  initial begin
    int s, nb, ab;
    rst = 1'b1;
    cs[0] = 1'b1;  cs[1] = 1'b1;
    sck[0] = 1'b0; sck[1] = 1'b1;
    mosi[0] = 1'b0; mosi[1] = 1'b0;
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    tx_data[0] = '0; tx_data[1] = '0;
    und_cnt[0] = 0; und_cnt[1] = 0;
    und_exp[0] = 0; und_exp[1] = 0;
    clear_plan();
    fork monitor(); join_none
    repeat (4) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with slot preloaded
    do_write(0, 8'hA5);
    check("ready_full", 32'(ready[0]), 0);
    mo[0] = 8'h3C;
    run_frame(0, 1, -1, 1'b0);
    check("ready_after_fall", 32'(ready_after_fall), 1);

    // Two bytes, second TX word written during the first byte
    clear_plan();
    do_write(0, 8'h11);
    mo[0] = 8'h55; mo[1] = 8'hAA;
    wr_en[0] = 1'b1; wr_data[0] = 8'h22;
    run_frame(0, 2, -1, 1'b0);

    // Underrun
    clear_plan();
    mo[0] = 8'h00;
    run_frame(0, 1, -1, 1'b0);

    // Abort after 5 bits; a word written mid-frame stays in the slot
    clear_plan();
    do_write(0, 8'h5A);
    mo[0] = 8'hF0; wr_en[0] = 1'b1; wr_data[0] = 8'hE7;
    run_frame(0, 1, 5, 1'b0);
    clear_plan();
    mo[0] = 8'h81;
    run_frame(0, 1, -1, 1'b0);

    // Mode 3 instance
    clear_plan();
    do_write(1, 8'h96);
    mo[0] = 8'h69;
    run_frame(1, 1, -1, 1'b0);

    // Reset mid-byte, then a clean transfer
    clear_plan();
    do_write(0, 8'h77);
    mo[0] = 8'hB4;
    run_frame(0, 1, 4, 1'b1);
    clear_plan();
    do_write(0, 8'h3C);
    mo[0] = 8'hC3;
    run_frame(0, 1, -1, 1'b0);

    // Randomised frames on both instances
    for (int k = 0; k < 24; k++) begin
      s  = int'($urandom % 2);
      nb = 1 + int'($urandom % 3);
      ab = ($urandom % 5 == 0) ? 1 + int'($urandom % 7) : -1;
      for (int i = 0; i < 4; i++) begin
        mo[i]      = 8'($urandom);
        wr_en[i]   = 1'($urandom);
        wr_data[i] = 8'($urandom);
      end
      if (model_size(s) == 0 && ($urandom % 2) == 1) do_write(s, 8'($urandom));
      run_frame(s, nb, ab, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
